// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// The optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Digit counter width; a single-slice run still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig > 32'd1) ? unsigned'($clog2(ndig)) : 32'd1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: {bout, dif} = x - y - bi.
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] dif,
    output logic             bout
);

    logic brw;

    always_comb begin
        dif = '0;
        brw = bi;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dif[i] = x[i] ^ y[i] ^ brw;
            brw    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
        end
        bout = brw;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor d = a - b - bin, one DIGIT-bit slice per clock, LSB slice first.
// Defining SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = cnt_width(NDIG);
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DIGIT-1:0] dig;
    logic             dig_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             am_q, am_d, bm_q, bm_d;
`endif

    // Single slice unit; operands are shifted down so slice k is always at the bottom.
    sub_digit #(
        .DIGIT(DIGIT)
    ) u_sub_digit (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .bi  (br_q),
        .dif (dig),
        .bout(dig_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SERIAL_SUB_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                end
            end
            StRun: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                // New slice enters at the MSB end; after NDIG shifts it lands in place.
                d_d   = (d_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
                br_d  = dig_bo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign d         = d_q;
    assign bo        = br_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = (am_q != bm_q) && (d_q[WIDTH-1] != am_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (16/4 and single-slice 8/8) and the sub_digit slice unit.
// Checks ovf only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W    = 16;
    localparam int unsigned DG   = 4;
    localparam int unsigned NDIG = W / DG;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, bin, out_valid, out_ready, bo;
    logic [W-1:0]  a, b, d;
    logic          in_valid8, in_ready8, bin8, out_valid8, out_ready8, bo8;
    logic [7:0]    a8, b8, d8;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf, ovf8;
`endif
    logic [3:0]    dx, dy, ddif;
    logic          dbi, dbout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W), .DIGIT(DG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bo(bo)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .d(d8), .bo(bo8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    sub_digit #(.DIGIT(4)) u_dig (.x(dx), .y(dy), .bi(dbi), .dif(ddif), .bout(dbout));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model of the 16-bit unit: 0 idle, 1 computing, 2 result held.
    int          m_st;
    int          m_left;
    logic [W-1:0] m_d;
    logic        m_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic        m_ovf;

    function automatic logic sovf(input logic [15:0] x, input logic [15:0] y, input logic bi);
        int s;
        s = 32'($signed(x)) - 32'($signed(y)) - 32'(bi);
        return (s > 32767) || (s < -32768);
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st   <= 0;
            m_left <= 0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_st          <= 1;
                    m_left        <= int'(NDIG);
                    {m_bo, m_d}   <= {1'b0, a} - {1'b0, b} - {16'b0, bin};
`ifdef SERIAL_SUB_OVF_EN
                    m_ovf         <= sovf(a, b, bin);
`endif
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_st <= 2;
                end
                default: if (out_ready) m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc in_ready", 32'(in_ready), 32'(m_st == 0));
            chk("cyc out_valid", 32'(out_valid), 32'(m_st == 2));
            if (m_st == 2) begin
                chk("cyc d", 32'(d), 32'(m_d));
                chk("cyc bo", 32'(bo), 32'(m_bo));
`ifdef SERIAL_SUB_OVF_EN
                chk("cyc ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic run16(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input logic [15:0] ed, input logic eb,
                         input logic eo, input bit bp);
        int n;
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = !bp;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, 32'(lat), NDIG);
        chk({nm, " d"}, 32'(d), 32'(ed));
        chk({nm, " bo"}, 32'(bo), 32'(eb));
        chk({nm, " model d"}, 32'(m_d), 32'(ed));
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) n = 0;
`endif
        if (!bp) begin
            @(posedge clk); #1;
            chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
            chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [16:0] e17;
        logic [8:0]  e9;
        int          n;
        int          lat;
        rst_n = 1'b1;
        in_valid = 0; a = '0; b = '0; bin = 0; out_ready = 1;
        in_valid8 = 0; a8 = '0; b8 = '0; bin8 = 0; out_ready8 = 1;
        dx = '0; dy = '0; dbi = 0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst d", 32'(d), 32'd0);
        chk("rst bo", 32'(bo), 32'd0);
        chk("rst8 in_ready", 32'(in_ready8), 32'd1);
        chk("rst8 out_valid", 32'(out_valid8), 32'd0);
        chk("rst8 d", 32'(d8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst ovf", 32'(ovf), 32'd0);
`endif

        for (int v = 0; v < 512; v++) begin
            {dbi, dx, dy} = 9'(v);
            #1;
            e9 = {5'b0, dx} - {5'b0, dy} - {8'b0, dbi};
            chk("sub_digit", 32'({dbout, ddif}), 32'(e9[4:0]));
        end

        @(negedge clk); #2 rst_n = 1'b1;

        run16("t1", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        run16("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run16("t2b", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run16("eq", 16'h3C3C, 16'h3C3C, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run16("zero_ones", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Backpressure: result must hold while inputs wiggle.
        run16("t3", 16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = ~a; b = a ^ 16'h1111; in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("t3 hold d", 32'(d), 32'h4B4B);
            chk("t3 hold bo", 32'(bo), 32'd0);
            chk("t3 hold in_ready", 32'(in_ready), 32'd0);
            chk("t3 hold out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3 single handshake", 32'(out_valid), 32'd0);
        chk("t3 in_ready back", 32'(in_ready), 32'd1);

        // Reset during the second RUN cycle.
        a = 16'hBEEF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t4 out_valid", 32'(out_valid), 32'd0);
        chk("t4 in_ready", 32'(in_ready), 32'd1);
        chk("t4 d", 32'(d), 32'd0);
        chk("t4 bo", 32'(bo), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        run16("t4", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

        run16("t5a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run16("t5b", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0, 1'b0, 1'b0);

        // Single-slice unit, back-to-back random operations.
        @(posedge clk); #1;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); in_valid8 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!in_ready8 && n < 10) begin
                @(posedge clk); #1; n++;
            end
            chk("t6 in_ready", 32'(in_ready8), 32'd1);
            e17 = {9'b0, 1'b0, a8} - {9'b0, 1'b0, b8} - {16'b0, bin8};
            @(posedge clk); #1;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            lat = 0;
            while (!out_valid8 && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            chk("t6 latency", 32'(lat), 32'd1);
            chk("t6 result", 32'({bo8, d8}), 32'(e17[8:0]));
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised, multi-cycle, digit-serial subtractor computing `d = a - b - bin` over `WIDTH` bits, one `DIGIT`-bit slice per clock, LSB slice first. A registered borrow links the slices. Operands are accepted and results returned over valid/ready handshakes. It is the sequential, width-generic successor to the single-bit half/full subtractor cells, and sits in datapaths where area matters more than single-cycle latency.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle. `DIGIT == WIDTH` gives a single-slice run.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: operands `a`, `b`, `bin` are valid.
- `in_ready` output, 1 bit: the block can accept operands.
- `a` input, WIDTH bits: minuend.
- `b` input, WIDTH bits: subtrahend.
- `bin` input, 1 bit: borrow-in, subtracted at bit 0.
- `out_valid` output, 1 bit: the result is valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `d` output, WIDTH bits: difference.
- `bo` output, 1 bit: borrow-out from the MSB. `bo` = 1 when `a < b + bin` (unsigned).
- `ovf` output, 1 bit: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- `NDIG = WIDTH/DIGIT`. Digit counter width is `$clog2(NDIG)`, minimum 1 bit.
- FSM states:
  - `IDLE`: `in_ready = 1`.
    - On `in_valid && in_ready`: latch `a`, `b`, `bin` into shift registers, set borrow register to `bin`, clear counter, go to `RUN`.
  - `RUN`: each cycle, slice k is computed as `{br', dk} = ak - bk - br`.
    - `dk` shifts into the result register from the MSB side. `br <= br'`. Counter increments.
    - After the slice with counter value `NDIG-1`, go to `DONE`.
  - `DONE`: `out_valid = 1`; `d`, `bo` (and `ovf`) held stable.
    - On `out_valid && out_ready`: go to `IDLE`.
- `in_ready` is high only in `IDLE`. `out_valid` is high only in `DONE`. Both are driven from state, with no combinational path from `in_valid` or `out_ready`.
- Input changes while not in `IDLE` are ignored. Operands are captured only at acceptance.
- Arithmetic is modulo 2^WIDTH.
  - `bo` is the final borrow register value.
  - The result must match `{bo, d} = {1'b0, a} - {1'b0, b} - bin` in WIDTH+1 bits.
- Boundary cases:
  - `a == b`, `bin = 0` gives `d = 0`, `bo = 0`.
  - `a == b`, `bin = 1` gives `d` all ones, `bo = 1`.
  - `a = 0`, `b` = all ones, `bin = 1` gives `d = 0`, `bo = 1`.
- Reset while in `RUN` or `DONE` aborts the operation. No result is emitted and the block returns to `IDLE`.

## Timing
- Reset values: state `IDLE`, `in_ready = 1`, `out_valid = 0`, `d = 0`, `bo = 0`, `ovf = 0`. The counter and internal registers are 0.
- Acceptance edge E0. `out_valid` rises after edge E0+NDIG, so latency is NDIG cycles.
- The earliest next acceptance is the edge after the output handshake. Minimum initiation interval is NDIG+2 cycles.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle.
- Under backpressure, `d`, `bo` and `ovf` stay constant until the handshake cycle.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])`, using the latched operand MSBs. Valid in `DONE`, reset to 0.
- `SERIAL_SUB_OVF_EN` not defined:
  - No `ovf` port.
  - No MSB capture registers.
  - All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - FSM state typedef (`IDLE`, `RUN`, `DONE`, 2-bit encoding).
  - A function returning the counter width for a given NDIG.
- Sub-module `sub_digit`: a combinational DIGIT-bit ripple subtractor with ports `x`, `y`, `bi`, `dif`, `bout`.
  - Instantiated once and reused each RUN cycle.
  - Verified standalone, exhaustively for `DIGIT = 4`.

## Test plan
- Test 1 (WIDTH=16, DIGIT=4): `a = 0x1234`, `b = 0x0235`, `bin = 0`. Required: `d = 0x0FFF`, `bo = 0`, `out_valid` exactly 4 cycles after acceptance.
- Test 2: `a = 0x0000`, `b = 0x0001`, `bin = 0` gives `d = 0xFFFF`, `bo = 1`. Then `a = 0x0005`, `b = 0x0005`, `bin = 1` gives `d = 0xFFFF`, `bo = 1`.
- Test 3 (backpressure): hold `out_ready = 0` for 3 cycles in `DONE`, toggling `a`/`b`/`in_valid`. Required: `d`/`bo` unchanged, `in_ready = 0` throughout, single handshake once `out_ready = 1`.
- Test 4 (reset mid-run): assert `rst_n = 0` at the second RUN cycle. Required: immediately `out_valid = 0`, `in_ready = 1`, `d = 0`. The next operation `0x00FF - 0x000F` gives `0x00F0`.
- Test 5 (`SERIAL_SUB_OVF_EN`): `a = 0x8000`, `b = 0x0001` gives `d = 0x7FFF`, `ovf = 1`. Then `a = 0x7FFF`, `b = 0x0001` gives `ovf = 0`.
- Test 6: WIDTH=8, DIGIT=8 (single slice), 1000 random back-to-back operations checked against the WIDTH+1-bit reference subtraction.
